// File: rtl/pipe_skid_register.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
//
// Ports:
//   clk, reset        - rising-edge clock, asynchronous active-high reset
//   flush             - empties the stage, reloads data with BUBBLE, drops the input beat
//   in_valid/in_ready/in_data    - upstream handshake; in_ready is registered
//   out_valid/out_ready/out_data - downstream handshake; out_* driven from the main register
//   occupancy         - number of held beats (0..2), registered
//   cnt_clear         - synchronous clear of both performance counters
//   stall_cnt         - saturating count of cycles with out_valid & ~out_ready
//   flush_cnt         - saturating count of cycles with flush asserted
//
// in_ready depends only on skid occupancy, so out_ready never reaches in_ready
// combinationally; the skid entry absorbs the one beat accepted while the stall
// propagates.
module pipe_skid_register #(
  parameter int unsigned        DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned        CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding is {skid_v, main_v}, so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StOne   = 2'b01,
    StTwo   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              in_fire, out_fire;

  assign in_ready  = (state_q != StTwo);
  assign out_valid = (state_q != StEmpty);
  assign out_data  = main_data_q;
  assign occupancy = {state_q == StTwo, state_q == StOne};
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d     = StEmpty;
      main_data_d = BUBBLE;
      skid_data_d = BUBBLE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_data_d = in_data;
            state_d     = StOne;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
          end else if (in_fire) begin
            skid_data_d = in_data;
            state_d     = StTwo;
          end else if (out_fire) begin
            // main data is left stale; out_valid low marks it as meaningless.
            state_d = StEmpty;
          end
        end
        StTwo: begin
          if (out_fire) begin
            main_data_d = skid_data_q;
            state_d     = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_q != {CNT_W{1'b1}}) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (flush && flush_cnt_q != {CNT_W{1'b1}}) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      main_data_q <= BUBBLE;
      skid_data_q <= BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: doc/pipe_skid_register.md
Name: pipe_skid_register

Overview:
- Parametrised elastic pipeline-stage register that supersedes the fixed stall/flush inter-stage registers used between fetch, decode, execute, memory and writeback.
- Adds valid/ready handshaking and a 2-entry skid buffer, so backpressure does not create a combinational ready path across stages.
- Flush reloads the stage with a configurable bubble word (e.g. a NOP).
- Saturating stall and flush counters support pipeline performance measurement.

Parameters:
- DATA_W, 64, width of the payload carried through the stage.
- BUBBLE, {DATA_W{1'b0}}, value loaded into the data registers on reset and flush (set to 32'h00000013 for instruction payloads).
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  discard all held entries and the current input beat.
- in_valid  in  1  upstream has a beat on in_data.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a valid beat; registered.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload, driven straight from the main register.
- occupancy  out  2  number of held entries (0, 1 or 2).
- cnt_clear  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
- flush_cnt  out  CNT_W  cycles with flush=1; saturating.

Behaviour:
- Definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage: a main register (main_d, main_v) and a skid register (skid_d, skid_v).
  - out_data = main_d, out_valid = main_v.
  - in_ready = ~skid_v.
- Reset (asynchronous, while reset=1):
  - main_v = skid_v = 0.
  - main_d = skid_d = BUBBLE.
  - in_ready = 1, out_valid = 0, occupancy = 0.
  - stall_cnt = flush_cnt = 0.
- Reset asserted mid-transfer drops every held beat with no output. The first accept is possible in the first clk edge after reset deasserts.
- States are derived from the valid bits: EMPTY (main_v=0), ONE (main_v=1, skid_v=0), TWO (both valid). Transitions when flush=0:
  - EMPTY, in_fire: main<=in_data, go to ONE.
  - EMPTY, no in_fire: hold in EMPTY.
  - ONE, in_fire & out_fire: main<=in_data, stay in ONE. This is full throughput, one beat per cycle.
  - ONE, in_fire only: skid<=in_data, go to TWO.
  - ONE, out_fire only: go to EMPTY; main_d keeps its stale value.
  - ONE, neither: hold.
  - TWO: in_ready=0, so no input is accepted.
  - TWO, out_fire: main<=skid_d, skid_v<=0, go to ONE.
  - TWO, no out_fire: hold; data stays stable.
- The invariant skid_v=1 implies main_v=1 always holds.
- Flush has highest priority:
  - Next state is EMPTY.
  - main_d and skid_d are loaded with BUBBLE.
  - An input beat presented in the flush cycle is discarded, even if in_fire=1.
  - An out_fire in the flush cycle counts as a completed transfer for the consumer.
  - in_ready and out_valid are registered, so the flush shows on them from the next cycle.
- Ordering: beats leave in strict FIFO order, with no duplication or loss except on flush or reset.
- occupancy = main_v + skid_v, with registered timing.
- Latency: a beat accepted at edge N is visible on out_data/out_valid after edge N (zero bubbles in steady state).
- Counters:
  - Each counter increments by 1 per qualifying cycle.
  - Each holds at 2^CNT_W-1 and does not wrap.
  - cnt_clear has priority over increment: clear and qualify in the same cycle gives 0 next.
  - Counters are not affected by flush; only reset or cnt_clear zero them.
- The stage contains no combinational path from out_ready to in_ready, or from in_valid to out_valid.

Test Plan:
- Streaming: DATA_W=32, out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles → out_data 1,2,3,4 one cycle later, back-to-back; occupancy stays at 1; stall_cnt=0.
- Backpressure: send A=0xAA and B=0xBB while out_ready=0 → in_ready falls after B is accepted; occupancy=2; C held at the input is not accepted; stall_cnt increments each cycle. Then raise out_ready → outputs AA, BB, CC in order with no loss.
- Flush in TWO with in_valid=1 (data 0x55) → next cycle out_valid=0, in_ready=1, occupancy=0, out_data=BUBBLE=0x00000013; 0x55 never appears; flush_cnt=1.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt reaches 15 and holds. cnt_clear together with a stall cycle → stall_cnt=0 next cycle.
- Async reset: assert reset between clk edges while occupancy=2 → outputs go to reset values immediately. After deassert, the next beat 0x77 emerges alone with no stale data.
- Random: 10k cycles of random in_valid, out_ready and flush, checked against a reference FIFO with flush-clear → in-order delivery; in_ready=0 only when occupancy=2.
